// File: rtl/ct_piu_snb_rd_sched.sv
// ---------------------------------------------------------------------------
// ct_piu_snb_rd_sched
//
// Read-channel scheduler between one PIU read source and the two SNB banks.
//
//   AR path : holds a single read request, steers it to snb0 or snb1 using
//             bit SEL_BIT of the AR payload, and keeps the request asserted
//             until the addressed bank grants it. Each bank has an
//             outstanding-read counter; a bank that already has MAX_OUTST
//             reads in flight blocks new requests to it.
//   R path  : round-robins the banks' rvalid into a one-entry output
//             register. Once the consumer takes the data, a one-cycle rack
//             and the read's sid go back to the bank that supplied it.
//
// Ports
//   forever_cpuclk          clock, every flop on the rising edge
//   cpurst                  asynchronous reset, active-high
//   piu_ar_vld/bus/rdy      source AR handshake and payload
//   piu_snbX_ar_req/bus     AR request and payload to bank X (bus zero when idle)
//   snbX_piu_ar_grant       bank X accepts the pending AR request
//   snbX_piu_rvalid/rbus    bank X read data valid and payload
//   piu_snbX_r_grant        same-cycle capture strobe of bank X rbus
//   piu_snbX_rack           one-cycle read acknowledge to bank X
//   piu_snbx_rack_sid       sid of the acknowledged read, zero when no rack
//   piu_r_vld/bus/rdy       output read data handshake and payload
//   piu_xx_no_op            high when the block holds no read activity
// ---------------------------------------------------------------------------
module ct_piu_snb_rd_sched #(
    parameter int ARWIDTH    = 71,
    parameter int UPKB_WIDTH = 535,
    parameter int SEL_BIT    = 6,
    parameter int SID_LSB    = 0,
    parameter int MAX_OUTST  = 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    // source AR channel
    input  logic                  piu_ar_vld,
    input  logic [ARWIDTH-1:0]    piu_ar_bus,
    output logic                  piu_ar_rdy,
    // AR channel to the banks
    output logic                  piu_snb0_ar_req,
    output logic                  piu_snb1_ar_req,
    output logic [ARWIDTH-1:0]    piu_snb0_ar_bus,
    output logic [ARWIDTH-1:0]    piu_snb1_ar_bus,
    input  logic                  snb0_piu_ar_grant,
    input  logic                  snb1_piu_ar_grant,
    // R channel from the banks
    input  logic                  snb0_piu_rvalid,
    input  logic                  snb1_piu_rvalid,
    input  logic [UPKB_WIDTH-1:0] snb0_piux_rbus,
    input  logic [UPKB_WIDTH-1:0] snb1_piux_rbus,
    output logic                  piu_snb0_r_grant,
    output logic                  piu_snb1_r_grant,
    output logic                  piu_snb0_rack,
    output logic                  piu_snb1_rack,
    output logic [4:0]            piu_snbx_rack_sid,
    // output R channel
    output logic                  piu_r_vld,
    output logic [UPKB_WIDTH-1:0] piu_r_bus,
    input  logic                  piu_r_rdy,
    // activity status
    output logic                  piu_xx_no_op
);

    localparam int              CW      = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUTST);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    typedef enum logic {
        AR_IDLE,
        AR_REQ
    } ar_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_HOLD,
        R_ACK
    } r_state_t;

    ar_state_t       ar_state;
    logic            ar_bank;        // bank of the pending AR request (1 = snb1)
    logic            ar_sel_bank;    // bank addressed by the incoming payload
    logic [CW-1:0]   ar_sel_cnt;     // outstanding count of that bank
    logic            ar_accept;
    logic            ar_grant_hit;   // pending request granted by its own bank

    r_state_t        r_state;
    logic            r_bank;         // bank of the read held in the output register
    logic            rr_ptr;         // bank preferred when both rvalid are high

    logic [CW-1:0]   cnt0;
    logic [CW-1:0]   cnt1;
    logic            cnt0_inc;
    logic            cnt1_inc;

    // -----------------------------------------------------------------------
    // AR path
    // -----------------------------------------------------------------------
    assign ar_sel_bank  = piu_ar_bus[SEL_BIT];
    assign ar_sel_cnt   = ar_sel_bank ? cnt1 : cnt0;
    assign piu_ar_rdy   = (ar_state == AR_IDLE) && (ar_sel_cnt != CNT_MAX);
    assign ar_accept    = piu_ar_vld && piu_ar_rdy;

    // A grant from the bank that was not addressed is simply ignored.
    assign ar_grant_hit = (ar_state == AR_REQ) &&
                          (ar_bank ? snb1_piu_ar_grant : snb0_piu_ar_grant);

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            ar_state        <= AR_IDLE;
            ar_bank         <= 1'b0;
            piu_snb0_ar_req <= 1'b0;
            piu_snb1_ar_req <= 1'b0;
            piu_snb0_ar_bus <= '0;
            piu_snb1_ar_bus <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (ar_accept) begin
                        ar_state        <= AR_REQ;
                        ar_bank         <= ar_sel_bank;
                        piu_snb0_ar_req <= ~ar_sel_bank;
                        piu_snb1_ar_req <= ar_sel_bank;
                        piu_snb0_ar_bus <= ar_sel_bank ? '0 : piu_ar_bus;
                        piu_snb1_ar_bus <= ar_sel_bank ? piu_ar_bus : '0;
                    end
                end
                AR_REQ: begin
                    // Request and payload stay frozen until the bank grants.
                    if (ar_grant_hit) begin
                        ar_state        <= AR_IDLE;
                        piu_snb0_ar_req <= 1'b0;
                        piu_snb1_ar_req <= 1'b0;
                        piu_snb0_ar_bus <= '0;
                        piu_snb1_ar_bus <= '0;
                    end
                end
                default: ar_state <= AR_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // R path: bank selection happens in the same cycle as rvalid
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        piu_snb0_r_grant = 1'b0;
        piu_snb1_r_grant = 1'b0;
        if (r_state == R_IDLE) begin
            // A lone rvalid wins outright; a tie goes to the bank rr_ptr names.
            piu_snb0_r_grant = snb0_piu_rvalid && (!snb1_piu_rvalid || !rr_ptr);
            piu_snb1_r_grant = snb1_piu_rvalid && (!snb0_piu_rvalid ||  rr_ptr);
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state           <= R_IDLE;
            r_bank            <= 1'b0;
            rr_ptr            <= 1'b0;
            piu_r_vld         <= 1'b0;
            piu_r_bus         <= '0;
            piu_snb0_rack     <= 1'b0;
            piu_snb1_rack     <= 1'b0;
            piu_snbx_rack_sid <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (piu_snb0_r_grant || piu_snb1_r_grant) begin
                        r_state   <= R_HOLD;
                        r_bank    <= piu_snb1_r_grant;
                        // Next tie goes to the bank that was not just served.
                        rr_ptr    <= ~piu_snb1_r_grant;
                        piu_r_vld <= 1'b1;
                        piu_r_bus <= piu_snb1_r_grant ? snb1_piux_rbus : snb0_piux_rbus;
                    end
                end
                R_HOLD: begin
                    if (piu_r_rdy) begin
                        r_state           <= R_ACK;
                        piu_r_vld         <= 1'b0;
                        piu_r_bus         <= '0;
                        piu_snb0_rack     <= ~r_bank;
                        piu_snb1_rack     <= r_bank;
                        piu_snbx_rack_sid <= piu_r_bus[SID_LSB +: 5];
                    end
                end
                R_ACK: begin
                    r_state           <= R_IDLE;
                    piu_snb0_rack     <= 1'b0;
                    piu_snb1_rack     <= 1'b0;
                    piu_snbx_rack_sid <= '0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outstanding-read counters: +1 on AR grant, -1 on rack
    // -----------------------------------------------------------------------
    assign cnt0_inc = ar_grant_hit && !ar_bank;
    assign cnt1_inc = ar_grant_hit &&  ar_bank;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            // Increment and decrement in the same cycle cancel out. A rack at
            // zero (a read the counter never saw) leaves the count at zero.
            case ({cnt0_inc, piu_snb0_rack})
                2'b10:   cnt0 <= cnt0 + CNT_ONE;
                2'b01:   if (cnt0 != '0) cnt0 <= cnt0 - CNT_ONE;
                default: cnt0 <= cnt0;
            endcase
            case ({cnt1_inc, piu_snb1_rack})
                2'b10:   cnt1 <= cnt1 + CNT_ONE;
                2'b01:   if (cnt1 != '0) cnt1 <= cnt1 - CNT_ONE;
                default: cnt1 <= cnt1;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Activity status
    // -----------------------------------------------------------------------
    assign piu_xx_no_op = (ar_state == AR_IDLE) && (r_state == R_IDLE) &&
                          (cnt0 == '0) && (cnt1 == '0) && !piu_ar_vld;

endmodule

// File: tb/tb_ct_piu_snb_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_ct_piu_snb_rd_sched
//
// Directed bench for ct_piu_snb_rd_sched. Inputs change 2 time units after a
// rising clock edge; outputs are sampled 1 unit later, mid-cycle. Expected
// values are hand-derived constants for each step.
// ---------------------------------------------------------------------------
module tb_ct_piu_snb_rd_sched;

    localparam int ARWIDTH    = 71;
    localparam int UPKB_WIDTH = 535;
    localparam int SEL_BIT    = 6;
    localparam int SID_LSB    = 0;
    localparam int MAX_OUTST  = 8;

    logic                  forever_cpuclk;
    logic                  cpurst;
    logic                  piu_ar_vld;
    logic [ARWIDTH-1:0]    piu_ar_bus;
    logic                  piu_ar_rdy;
    logic                  piu_snb0_ar_req;
    logic                  piu_snb1_ar_req;
    logic [ARWIDTH-1:0]    piu_snb0_ar_bus;
    logic [ARWIDTH-1:0]    piu_snb1_ar_bus;
    logic                  snb0_piu_ar_grant;
    logic                  snb1_piu_ar_grant;
    logic                  snb0_piu_rvalid;
    logic                  snb1_piu_rvalid;
    logic [UPKB_WIDTH-1:0] snb0_piux_rbus;
    logic [UPKB_WIDTH-1:0] snb1_piux_rbus;
    logic                  piu_snb0_r_grant;
    logic                  piu_snb1_r_grant;
    logic                  piu_snb0_rack;
    logic                  piu_snb1_rack;
    logic [4:0]            piu_snbx_rack_sid;
    logic                  piu_r_vld;
    logic [UPKB_WIDTH-1:0] piu_r_bus;
    logic                  piu_r_rdy;
    logic                  piu_xx_no_op;

    int errors = 0;
    int checks = 0;

    // AR payloads: bit 6 clear -> snb0, bit 6 set -> snb1
    logic [ARWIDTH-1:0]    pa0 = 71'h12_3456_789A_BCDE_F08F;
    logic [ARWIDTH-1:0]    pa1 = 71'h7F_0011_2233_4455_66C1;
    // R payloads with sids 5'h03, 5'h0A and 5'h15 in the low five bits
    logic [UPKB_WIDTH-1:0] rb0  = 535'h5A5A_1234_0043;
    logic [UPKB_WIDTH-1:0] rb0b = 535'hC0FF_EE00_9876_002A;
    logic [UPKB_WIDTH-1:0] rb1  = 535'h7777_DEAD_BEEF_0035;

    ct_piu_snb_rd_sched #(
        .ARWIDTH    (ARWIDTH),
        .UPKB_WIDTH (UPKB_WIDTH),
        .SEL_BIT    (SEL_BIT),
        .SID_LSB    (SID_LSB),
        .MAX_OUTST  (MAX_OUTST)
    ) dut (
        .forever_cpuclk    (forever_cpuclk),
        .cpurst            (cpurst),
        .piu_ar_vld        (piu_ar_vld),
        .piu_ar_bus        (piu_ar_bus),
        .piu_ar_rdy        (piu_ar_rdy),
        .piu_snb0_ar_req   (piu_snb0_ar_req),
        .piu_snb1_ar_req   (piu_snb1_ar_req),
        .piu_snb0_ar_bus   (piu_snb0_ar_bus),
        .piu_snb1_ar_bus   (piu_snb1_ar_bus),
        .snb0_piu_ar_grant (snb0_piu_ar_grant),
        .snb1_piu_ar_grant (snb1_piu_ar_grant),
        .snb0_piu_rvalid   (snb0_piu_rvalid),
        .snb1_piu_rvalid   (snb1_piu_rvalid),
        .snb0_piux_rbus    (snb0_piux_rbus),
        .snb1_piux_rbus    (snb1_piux_rbus),
        .piu_snb0_r_grant  (piu_snb0_r_grant),
        .piu_snb1_r_grant  (piu_snb1_r_grant),
        .piu_snb0_rack     (piu_snb0_rack),
        .piu_snb1_rack     (piu_snb1_rack),
        .piu_snbx_rack_sid (piu_snbx_rack_sid),
        .piu_r_vld         (piu_r_vld),
        .piu_r_bus         (piu_r_bus),
        .piu_r_rdy         (piu_r_rdy),
        .piu_xx_no_op      (piu_xx_no_op)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag,
                         input logic [UPKB_WIDTH-1:0] obs,
                         input logic [UPKB_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge forever_cpuclk);
        #2;
    endtask

    initial begin
        logic exp_bank;

        cpurst            = 1'b1;
        piu_ar_vld        = 1'b0;
        piu_ar_bus        = '0;
        snb0_piu_ar_grant = 1'b0;
        snb1_piu_ar_grant = 1'b0;
        snb0_piu_rvalid   = 1'b0;
        snb1_piu_rvalid   = 1'b0;
        snb0_piux_rbus    = '0;
        snb1_piux_rbus    = '0;
        piu_r_rdy         = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge forever_cpuclk);
        #2 cpurst = 1'b0;
        #1;
        check("rst_no_op",  piu_xx_no_op, 1);
        check("rst_ar_rdy", piu_ar_rdy, 1);
        check("rst_req0",   piu_snb0_ar_req, 0);
        check("rst_req1",   piu_snb1_ar_req, 0);
        check("rst_bus0",   piu_snb0_ar_bus, 0);
        check("rst_r_vld",  piu_r_vld, 0);
        check("rst_r_bus",  piu_r_bus, 0);
        check("rst_rack0",  piu_snb0_rack, 0);
        check("rst_sid",    piu_snbx_rack_sid, 0);

        // ---------------- 1: single snb0 read ----------------
        tick();
        piu_ar_vld = 1'b1;
        piu_ar_bus = pa0;
        #1;
        check("t1_ar_rdy", piu_ar_rdy, 1);
        check("t1_no_op_vld", piu_xx_no_op, 0);
        tick();
        piu_ar_vld        = 1'b0;
        snb0_piu_ar_grant = 1'b1;
        #1;
        check("t1_req0",    piu_snb0_ar_req, 1);
        check("t1_req1",    piu_snb1_ar_req, 0);
        check("t1_bus0",    piu_snb0_ar_bus, pa0);
        check("t1_bus1",    piu_snb1_ar_bus, 0);
        check("t1_rdy_req", piu_ar_rdy, 0);
        tick();
        snb0_piu_ar_grant = 1'b0;
        snb0_piu_rvalid   = 1'b1;
        snb0_piux_rbus    = rb0;
        #1;
        check("t1_req0_drop", piu_snb0_ar_req, 0);
        check("t1_bus0_zero", piu_snb0_ar_bus, 0);
        check("t1_cnt0",      dut.cnt0, 1);
        check("t1_no_op_out", piu_xx_no_op, 0);
        check("t1_rgrant0",   piu_snb0_r_grant, 1);
        check("t1_rgrant1",   piu_snb1_r_grant, 0);
        tick();
        #1;
        check("t1_r_vld",       piu_r_vld, 1);
        check("t1_r_bus",       piu_r_bus, rb0);
        check("t1_hold_nogrant", piu_snb0_r_grant, 0);
        snb0_piu_rvalid = 1'b0;
        piu_r_rdy       = 1'b1;
        tick();
        piu_r_rdy = 1'b0;
        #1;
        check("t1_rack0",  piu_snb0_rack, 1);
        check("t1_rack1",  piu_snb1_rack, 0);
        check("t1_sid",    piu_snbx_rack_sid, 5'h03);
        check("t1_vld_dn", piu_r_vld, 0);
        tick();
        #1;
        check("t1_rack_end", piu_snb0_rack, 0);
        check("t1_sid_end",  piu_snbx_rack_sid, 0);
        check("t1_cnt0_end", dut.cnt0, 0);
        check("t1_no_op",    piu_xx_no_op, 1);

        // ---------------- 2: steering to snb1 and stall ----------------
        piu_ar_vld = 1'b1;
        piu_ar_bus = pa1;
        #1;
        check("t2_ar_rdy", piu_ar_rdy, 1);
        tick();
        piu_ar_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            snb0_piu_ar_grant = (i == 2);
            #1;
            check("t2_req1_hold", piu_snb1_ar_req, 1);
            check("t2_req0_low",  piu_snb0_ar_req, 0);
            check("t2_bus1",      piu_snb1_ar_bus, pa1);
            check("t2_rdy_low",   piu_ar_rdy, 0);
            tick();
        end
        snb0_piu_ar_grant = 1'b0;
        snb1_piu_ar_grant = 1'b1;
        #1;
        check("t2_req1_at_grant", piu_snb1_ar_req, 1);
        tick();
        snb1_piu_ar_grant = 1'b0;
        #1;
        check("t2_req1_drop", piu_snb1_ar_req, 0);
        check("t2_cnt1",      dut.cnt1, 1);
        check("t2_cnt0_ign",  dut.cnt0, 0);

        // ---------------- 3: bank0 full ----------------
        for (int k = 0; k < 8; k++) begin
            piu_ar_vld = 1'b1;
            piu_ar_bus = pa0;
            #1;
            check("t3_fill_rdy", piu_ar_rdy, 1);
            tick();
            piu_ar_vld        = 1'b0;
            snb0_piu_ar_grant = 1'b1;
            tick();
            snb0_piu_ar_grant = 1'b0;
        end
        #1;
        check("t3_cnt0_full", dut.cnt0, 8);
        piu_ar_vld = 1'b1;
        piu_ar_bus = pa0;
        #1;
        check("t3_rdy_bank0", piu_ar_rdy, 0);
        piu_ar_bus = pa1;
        #1;
        check("t3_rdy_bank1", piu_ar_rdy, 1);
        piu_ar_vld = 1'b0;
        piu_ar_bus = pa0;

        // Serve the outstanding snb1 read; this leaves the RR pointer on snb0.
        tick();
        snb1_piu_rvalid = 1'b1;
        snb1_piux_rbus  = rb1;
        piu_r_rdy       = 1'b1;
        #1;
        check("t3_rgrant1", piu_snb1_r_grant, 1);
        tick();
        snb1_piu_rvalid = 1'b0;
        #1;
        check("t3_r_bus1", piu_r_bus, rb1);
        tick();
        #1;
        check("t3_rack1", piu_snb1_rack, 1);
        check("t3_sid1",  piu_snbx_rack_sid, 5'h15);
        tick();
        #1;
        check("t3_cnt1_zero", dut.cnt1, 0);

        // ---------------- 4: round robin with both rvalid ----------------
        snb0_piu_rvalid = 1'b1;
        snb1_piu_rvalid = 1'b1;
        snb0_piux_rbus  = rb0b;
        for (int k = 0; k < 3; k++) begin
            exp_bank = (k == 1);
            #1;
            check("t4_rgrant0", piu_snb0_r_grant, !exp_bank);
            check("t4_rgrant1", piu_snb1_r_grant, exp_bank);
            tick();
            #1;
            check("t4_r_vld", piu_r_vld, 1);
            check("t4_r_bus", piu_r_bus, exp_bank ? rb1 : rb0b);
            check("t4_hold_g", {piu_snb1_r_grant, piu_snb0_r_grant}, 0);
            tick();
            #1;
            check("t4_rack0", piu_snb0_rack, !exp_bank);
            check("t4_rack1", piu_snb1_rack, exp_bank);
            check("t4_sid",   piu_snbx_rack_sid, exp_bank ? 5'h15 : 5'h0A);
            tick();
        end
        snb1_piu_rvalid = 1'b0;
        #1;
        check("t4_cnt0",     dut.cnt0, 6);
        check("t4_cnt1_sat", dut.cnt1, 0);

        // Drain bank0 down to two outstanding reads.
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_drain_g", piu_snb0_r_grant, 1);
            tick();
            tick();
            #1;
            check("t4_drain_rack", piu_snb0_rack, 1);
            tick();
        end
        snb0_piu_rvalid = 1'b0;
        #1;
        check("t4_cnt0_two", dut.cnt0, 2);

        // ---------------- 5: grant and rack to snb0 in one cycle ----------------
        piu_ar_vld      = 1'b1;
        piu_ar_bus      = pa0;
        snb0_piu_rvalid = 1'b1;
        #1;
        check("t5_ar_rdy", piu_ar_rdy, 1);
        check("t5_rgrant", piu_snb0_r_grant, 1);
        tick();
        piu_ar_vld      = 1'b0;
        snb0_piu_rvalid = 1'b0;
        #1;
        check("t5_req0", piu_snb0_ar_req, 1);
        check("t5_rvld", piu_r_vld, 1);
        tick();
        snb0_piu_ar_grant = 1'b1;
        #1;
        check("t5_rack_now", piu_snb0_rack, 1);
        check("t5_req_now",  piu_snb0_ar_req, 1);
        tick();
        snb0_piu_ar_grant = 1'b0;
        piu_r_rdy         = 1'b0;
        #1;
        check("t5_cnt0_same", dut.cnt0, 2);
        check("t5_req0_drop", piu_snb0_ar_req, 0);

        // ---------------- 6: reset in AR_REQ and R_HOLD ----------------
        piu_ar_vld      = 1'b1;
        piu_ar_bus      = pa1;
        snb1_piu_rvalid = 1'b1;
        tick();
        piu_ar_vld      = 1'b0;
        snb1_piu_rvalid = 1'b0;
        #1;
        check("t6_req1_pre", piu_snb1_ar_req, 1);
        check("t6_rvld_pre", piu_r_vld, 1);
        cpurst = 1'b1;
        #1;
        check("t6_req1",  piu_snb1_ar_req, 0);
        check("t6_bus1",  piu_snb1_ar_bus, 0);
        check("t6_r_vld", piu_r_vld, 0);
        check("t6_r_bus", piu_r_bus, 0);
        check("t6_cnt0",  dut.cnt0, 0);
        check("t6_cnt1",  dut.cnt1, 0);
        check("t6_no_op", piu_xx_no_op, 1);
        tick();
        cpurst = 1'b0;
        #1;
        check("t6_no_op_after", piu_xx_no_op, 1);
        check("t6_rdy_after",   piu_ar_rdy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
